// File: rtl/piton_vortex_noc_req_deser_if.sv
// -----------------------------------------------------------------------------
// piton_vortex_noc_req_deser_if
// Bundles the flit-side and record-side signals of the NoC2 request
// deserializer.
//   Flit side  : splitter_deser_val / splitter_deser_data in,
//                deser_splitter_rdy out.
//   Record side: req_val and the req_* fields out, req_rdy in.
// Modports:
//   master - the environment. It sources flits and consumes records.
//   slave  - the deserializer itself.
// -----------------------------------------------------------------------------
interface piton_vortex_noc_req_deser_if #(
  parameter int NOC_DATA_WIDTH = 64,
  parameter int MAX_DATA_FLITS = 8,
  parameter int CNT_W          = 8
);
  logic                                     splitter_deser_val;
  logic [NOC_DATA_WIDTH-1:0]                splitter_deser_data;
  logic                                     deser_splitter_rdy;

  logic                                     req_val;
  logic                                     req_rdy;
  logic [7:0]                               req_type;
  logic [7:0]                               req_mshr;
  logic [7:0]                               req_len;
  logic [47:0]                              req_addr;
  logic [2:0]                               req_size;
  logic [29:0]                              req_src;
  logic [NOC_DATA_WIDTH*MAX_DATA_FLITS-1:0] req_data;
  logic [CNT_W-1:0]                         req_ndata;
  logic                                     req_err;

  modport master (
    output splitter_deser_val, splitter_deser_data, req_rdy,
    input  deser_splitter_rdy, req_val, req_type, req_mshr, req_len,
           req_addr, req_size, req_src, req_data, req_ndata, req_err
  );

  modport slave (
    input  splitter_deser_val, splitter_deser_data, req_rdy,
    output deser_splitter_rdy, req_val, req_type, req_mshr, req_len,
           req_addr, req_size, req_src, req_data, req_ndata, req_err
  );
endinterface

// File: rtl/piton_vortex_noc_req_deser.sv
// -----------------------------------------------------------------------------
// piton_vortex_noc_req_deser
// Rebuilds one OpenPiton NoC2 request packet from 64-bit flits into a single
// parallel request record. The record holds the header fields, the address,
// the source and up to MAX_DATA_FLITS payload words. Only one packet is held
// at a time. The flit input stalls while a record waits for the bridge.
// Ports:
//   sys_clk - clock
//   sys_rst - asynchronous, active-high reset
//   bus     - slave modport. It carries the flit handshake in and the
//             request record with its valid/ready handshake out.
// -----------------------------------------------------------------------------
module piton_vortex_noc_req_deser #(
  parameter int NOC_DATA_WIDTH = 64,
  parameter int MAX_DATA_FLITS = 8,
  parameter int CNT_W          = 8
) (
  input logic                           sys_clk,
  input logic                           sys_rst,
  piton_vortex_noc_req_deser_if.slave   bus
);

  localparam logic [2:0] S_HDR1 = 3'd0;
  localparam logic [2:0] S_HDR2 = 3'd1;
  localparam logic [2:0] S_HDR3 = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_HOLD = 3'd4;

  localparam int DW = NOC_DATA_WIDTH * MAX_DATA_FLITS;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] rem_q,   rem_d;
  logic [7:0]       type_q,  type_d;
  logic [7:0]       mshr_q,  mshr_d;
  logic [7:0]       len_q,   len_d;
  logic [47:0]      addr_q,  addr_d;
  logic [2:0]       size_q,  size_d;
  logic [29:0]      src_q,   src_d;
  logic [DW-1:0]    data_q,  data_d;
  logic [CNT_W-1:0] ndata_q, ndata_d;
  logic             err_q,   err_d;
  logic             accept;

  // Ready depends only on state, so a record in HOLD can never race a new flit.
  assign bus.deser_splitter_rdy = (state_q != S_HOLD);
  assign accept                 = bus.splitter_deser_val && bus.deser_splitter_rdy;

  always_comb begin
    // NOTE: every signal driven here gets its hold value first. Then no
    // path through the case leaves one unassigned, and no latch is inferred.
    state_d = state_q;
    rem_d   = rem_q;
    type_d  = type_q;
    mshr_d  = mshr_q;
    len_d   = len_q;
    addr_d  = addr_q;
    size_d  = size_q;
    src_d   = src_q;
    data_d  = data_q;
    ndata_d = ndata_q;
    err_d   = err_q;

    case (state_q)
      S_HDR1: if (accept) begin
        type_d  = bus.splitter_deser_data[21:14];
        mshr_d  = bus.splitter_deser_data[13:6];
        len_d   = bus.splitter_deser_data[29:22];
        data_d  = '0;
        ndata_d = '0;
        err_d   = 1'b0;
        rem_d   = bus.splitter_deser_data[29:22];
        if (bus.splitter_deser_data[29:22] == 8'd0) begin
          err_d   = 1'b1;
          state_d = S_HOLD;
        end else begin
          state_d = S_HDR2;
        end
      end

      S_HDR2: if (accept) begin
        addr_d = bus.splitter_deser_data[63:16];
        size_d = bus.splitter_deser_data[15:13];
        rem_d  = rem_q - CNT_W'(1);
        // A packet with no room for flit3 is truncated.
        if (rem_q == CNT_W'(1)) begin
          err_d   = 1'b1;
          state_d = S_HOLD;
        end else begin
          state_d = S_HDR3;
        end
      end

      S_HDR3: if (accept) begin
        src_d   = bus.splitter_deser_data[63:34];
        rem_d   = rem_q - CNT_W'(1);
        state_d = (rem_q == CNT_W'(1)) ? S_HOLD : S_DATA;
      end

      S_DATA: if (accept) begin
        if (ndata_q < CNT_W'(MAX_DATA_FLITS)) begin
          for (int i = 0; i < MAX_DATA_FLITS; i++) begin
            if (ndata_q == CNT_W'(i)) begin
              data_d[i*NOC_DATA_WIDTH +: NOC_DATA_WIDTH] = bus.splitter_deser_data;
            end
          end
          ndata_d = ndata_q + CNT_W'(1);
        end else begin
          // Payload longer than the record can hold: keep draining, flag it.
          err_d = 1'b1;
        end
        rem_d = rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1)) state_d = S_HOLD;
      end

      S_HOLD: if (bus.req_rdy) state_d = S_HDR1;

      default: state_d = S_HDR1;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= S_HDR1;
      rem_q   <= '0;
      type_q  <= '0;
      mshr_q  <= '0;
      len_q   <= '0;
      addr_q  <= '0;
      size_q  <= '0;
      src_q   <= '0;
      // NOTE: the payload array is reset as well. The record has to read back
      // as all zeros after reset, even though HDR1 clears it for each packet.
      data_q  <= '0;
      ndata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments. Every flop then
      // samples the values from before the edge, whatever the statement order.
      state_q <= state_d;
      rem_q   <= rem_d;
      type_q  <= type_d;
      mshr_q  <= mshr_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      src_q   <= src_d;
      data_q  <= data_d;
      ndata_q <= ndata_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_val   = (state_q == S_HOLD);
  assign bus.req_type  = type_q;
  assign bus.req_mshr  = mshr_q;
  assign bus.req_len   = len_q;
  assign bus.req_addr  = addr_q;
  assign bus.req_size  = size_q;
  assign bus.req_src   = src_q;
  assign bus.req_data  = data_q;
  assign bus.req_ndata = ndata_q;
  assign bus.req_err   = err_q;

endmodule

// File: tb/tb_piton_vortex_noc_req_deser.sv
// -----------------------------------------------------------------------------
// tb_piton_vortex_noc_req_deser
// Directed bench for the NoC2 request deserializer. Each scenario task drives
// flits and compares the presented record with the expected record. The
// expected record comes from hand values and a small packet model.
// -----------------------------------------------------------------------------
module tb_piton_vortex_noc_req_deser;
  localparam int W  = 64;
  localparam int M  = 8;
  localparam int C  = 8;
  localparam int DW = W * M;

  typedef struct packed {
    logic          val;
    logic [7:0]    typ;
    logic [7:0]    mshr;
    logic [7:0]    len;
    logic [47:0]   addr;
    logic [2:0]    size;
    logic [29:0]   src;
    logic [DW-1:0] data;
    logic [C-1:0]  ndata;
    logic          err;
  } rec_t;

  logic sys_clk = 1'b0;
  logic sys_rst;
  always #5 sys_clk = ~sys_clk;

  piton_vortex_noc_req_deser_if #(.NOC_DATA_WIDTH(W), .MAX_DATA_FLITS(M), .CNT_W(C)) bus ();

  piton_vortex_noc_req_deser #(.NOC_DATA_WIDTH(W), .MAX_DATA_FLITS(M), .CNT_W(C)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  int hold_accepts = 0;

  // Model state: header fields survive across packets until they are rewritten.
  logic [47:0] m_addr;
  logic [2:0]  m_size;
  logic [29:0] m_src;
  logic [63:0] words [0:15];

  // Counts any flit handshake that happens while a record is presented.
  always @(negedge sys_clk)
    if (!sys_rst && bus.req_val && bus.deser_splitter_rdy && bus.splitter_deser_val)
      hold_accepts++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic rec_t sample();
    rec_t s;
    s.val   = bus.req_val;
    s.typ   = bus.req_type;
    s.mshr  = bus.req_mshr;
    s.len   = bus.req_len;
    s.addr  = bus.req_addr;
    s.size  = bus.req_size;
    s.src   = bus.req_src;
    s.data  = bus.req_data;
    s.ndata = bus.req_ndata;
    s.err   = bus.req_err;
    return s;
  endfunction

  function automatic rec_t model(input logic [7:0] t, input logic [7:0] m, input logic [7:0] l);
    rec_t r;
    int   n;
    r      = '0;
    r.val  = 1'b1;
    r.typ  = t;
    r.mshr = m;
    r.len  = l;
    r.addr = m_addr;
    r.size = m_size;
    r.src  = m_src;
    n      = int'(l) - 2;
    for (int i = 0; i < n && i < M; i++) r.data[i*W +: W] = words[i];
    r.ndata = (n > M) ? C'(M) : ((n > 0) ? C'(n) : C'(0));
    r.err   = (l < 8'd2) || (n > M);
    return r;
  endfunction

  task automatic send_flit(input logic [63:0] f, input int bubbles);
    int guard;
    guard = 0;
    repeat (bubbles) begin
      @(negedge sys_clk);
      bus.splitter_deser_val = 1'b0;
    end
    @(negedge sys_clk);
    bus.splitter_deser_val  = 1'b1;
    bus.splitter_deser_data = f;
    while (!bus.deser_splitter_rdy && guard < 50) begin
      @(negedge sys_clk);
      guard++;
    end
    checks++;
    if (guard >= 50) begin
      errors++;
      $display("FAIL accept_timeout got_rdy=%0b req=1", bus.deser_splitter_rdy);
    end
    @(posedge sys_clk);
  endtask

  task automatic send_pkt(input logic [7:0] t, input logic [7:0] m, input logic [7:0] l,
                          input logic [47:0] addr, input logic [2:0] size,
                          input logic [29:0] src, input int maxb, input bit keep_val);
    int n;
    n = int'(l) - 2;
    send_flit({34'b0, l, t, m, 6'b0}, (maxb > 0) ? int'($urandom_range(maxb, 0)) : 0);
    if (l >= 8'd1) begin
      m_addr = addr;
      m_size = size;
      send_flit({addr, size, 13'b0}, (maxb > 0) ? int'($urandom_range(maxb, 0)) : 0);
    end
    if (l >= 8'd2) begin
      m_src = src;
      send_flit({src, 34'b0}, (maxb > 0) ? int'($urandom_range(maxb, 0)) : 0);
    end
    for (int i = 0; i < n; i++)
      send_flit(words[i], (maxb > 0) ? int'($urandom_range(maxb, 0)) : 0);
    if (!keep_val) begin
      #1 bus.splitter_deser_val = 1'b0;
    end
  endtask

  task automatic release_rec();
    @(negedge sys_clk);
    bus.req_rdy = 1'b1;
    @(posedge sys_clk);
    #1 bus.req_rdy = 1'b0;
  endtask

  task automatic test_reset();
    rec_t got;
    sys_rst                 = 1'b1;
    bus.splitter_deser_val  = 1'b0;
    bus.splitter_deser_data = '0;
    bus.req_rdy             = 1'b0;
    m_addr = '0; m_size = '0; m_src = '0;
    #1;
    got = sample();
    checks++;
    if (got !== rec_t'('0)) begin
      errors++;
      $display("FAIL reset_record got=%h exp=0", got);
    end
    checks++;
    if (bus.deser_splitter_rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_rdy got=%b exp=1", bus.deser_splitter_rdy);
    end
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b0;
  endtask

  task automatic test_read();
    rec_t got, exp;
    send_pkt(8'h0E, 8'h05, 8'd2, 48'h0000_1000_0040, 3'd3, 30'h1234, 0, 1'b0);
    @(negedge sys_clk);
    got = sample();
    exp = model(8'h0E, 8'h05, 8'd2);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL read_record got=%h exp=%h", got, exp);
    end
    checks++;
    if (got.addr !== 48'h000010000040 || got.size !== 3'd3 || got.ndata !== 8'd0 ||
        got.err !== 1'b0 || got.mshr !== 8'h05 || got.val !== 1'b1) begin
      errors++;
      $display("FAIL read_fields got_addr=%h size=%0d ndata=%0d err=%b mshr=%h val=%b",
               got.addr, got.size, got.ndata, got.err, got.mshr, got.val);
    end
    release_rec();
  endtask

  task automatic test_write();
    rec_t got, exp;
    words[0] = 64'hDEADBEEF00000001;
    words[1] = 64'h0000000000000002;
    send_pkt(8'h10, 8'h22, 8'd4, 48'h0000_0000_2000, 3'd3, 30'h55, 0, 1'b0);
    @(negedge sys_clk);
    got = sample();
    exp = model(8'h10, 8'h22, 8'd4);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL write_record got=%h exp=%h", got, exp);
    end
    checks++;
    if (got.ndata !== 8'd2 || got.data[63:0] !== 64'hDEADBEEF00000001 ||
        got.data[127:64] !== 64'd2 || got.data[DW-1:128] !== '0) begin
      errors++;
      $display("FAIL write_payload got_ndata=%0d w0=%h w1=%h exp 2/deadbeef00000001/2",
               got.ndata, got.data[63:0], got.data[127:64]);
    end
    // req_rdy stays low for 5 cycles in total; the record must stay presented.
    for (int i = 0; i < 4; i++) begin
      @(negedge sys_clk);
      checks++;
      if (bus.req_val !== 1'b1 || bus.deser_splitter_rdy !== 1'b0 || sample() !== exp) begin
        errors++;
        $display("FAIL write_stall cycle=%0d got_val=%b rdy=%b exp val=1 rdy=0",
                 i, bus.req_val, bus.deser_splitter_rdy);
      end
    end
    release_rec();
    @(negedge sys_clk);
    checks++;
    if (bus.req_val !== 1'b0 || bus.deser_splitter_rdy !== 1'b1) begin
      errors++;
      $display("FAIL write_resume got_val=%b rdy=%b exp val=0 rdy=1",
               bus.req_val, bus.deser_splitter_rdy);
    end
  endtask

  task automatic test_overflow();
    rec_t got, exp;
    for (int i = 0; i < 10; i++) words[i] = 64'h0000_0000_0000_0100 + 64'(i);
    send_pkt(8'h10, 8'h33, 8'd12, 48'h0000_0000_3000, 3'd3, 30'h77, 0, 1'b0);
    @(negedge sys_clk);
    got = sample();
    exp = model(8'h10, 8'h33, 8'd12);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL overflow_record got=%h exp=%h", got, exp);
    end
    checks++;
    if (got.ndata !== 8'd8 || got.err !== 1'b1 || got.data[DW-1:DW-W] !== 64'h107) begin
      errors++;
      $display("FAIL overflow_fields got_ndata=%0d err=%b w7=%h exp 8/1/107",
               got.ndata, got.err, got.data[DW-1:DW-W]);
    end
    release_rec();
  endtask

  task automatic test_malformed();
    rec_t got, exp;
    send_pkt(8'h0E, 8'h44, 8'd0, 48'h0, 3'd0, 30'h0, 0, 1'b0);
    @(negedge sys_clk);
    got = sample();
    exp = model(8'h0E, 8'h44, 8'd0);
    checks++;
    if (got !== exp || got.err !== 1'b1 || got.val !== 1'b1) begin
      errors++;
      $display("FAIL malformed_len0 got=%h exp=%h", got, exp);
    end
    release_rec();
    send_pkt(8'h0E, 8'h45, 8'd1, 48'h0000_ABCD_0008, 3'd2, 30'h0, 0, 1'b0);
    @(negedge sys_clk);
    got = sample();
    exp = model(8'h0E, 8'h45, 8'd1);
    checks++;
    if (got !== exp || got.err !== 1'b1 || got.addr !== 48'h0000ABCD0008) begin
      errors++;
      $display("FAIL malformed_len1 got=%h exp=%h", got, exp);
    end
    release_rec();
  endtask

  task automatic test_back_to_back();
    logic [7:0] lens [0:5];
    rec_t got, exp;
    lens[0] = 8'd2; lens[1] = 8'd3; lens[2] = 8'd5;
    lens[3] = 8'd10; lens[4] = 8'd4; lens[5] = 8'd1;
    hold_accepts = 0;
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < 8; i++) words[i] = {$urandom, $urandom};
      send_pkt(8'h20 + 8'(p), 8'h60 + 8'(p), lens[p], {16'h0, $urandom}, 3'(p),
               30'(p * 1000 + 7), 3, 1'b1);
      @(negedge sys_clk);
      got = sample();
      exp = model(8'h20 + 8'(p), 8'h60 + 8'(p), lens[p]);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL b2b_record pkt=%0d got=%h exp=%h", p, got, exp);
      end
      repeat ($urandom_range(3, 0)) begin
        @(negedge sys_clk);
        checks++;
        if (bus.deser_splitter_rdy !== 1'b0) begin
          errors++;
          $display("FAIL b2b_hold_rdy pkt=%0d got=%b exp=0", p, bus.deser_splitter_rdy);
        end
      end
      release_rec();
    end
    #1 bus.splitter_deser_val = 1'b0;
    checks++;
    if (hold_accepts !== 0) begin
      errors++;
      $display("FAIL b2b_hold_accepts got=%0d exp=0", hold_accepts);
    end
  endtask

  task automatic test_reset_mid_data();
    rec_t got, exp;
    words[0] = 64'hAAAA_AAAA_AAAA_AAAA;
    words[1] = 64'hBBBB_BBBB_BBBB_BBBB;
    send_flit({34'b0, 8'd4, 8'h01, 8'h02, 6'b0}, 0);
    send_flit({48'h0000_0000_5000, 3'd3, 13'b0}, 0);
    send_flit({30'h99, 34'b0}, 0);
    send_flit(words[0], 0);
    send_flit(words[1], 0);
    #2;
    sys_rst                = 1'b1;
    bus.splitter_deser_val = 1'b0;
    #1;
    got = sample();
    checks++;
    if (got !== rec_t'('0) || bus.deser_splitter_rdy !== 1'b1) begin
      errors++;
      $display("FAIL midreset_async got=%h rdy=%b exp=0 rdy=1", got, bus.deser_splitter_rdy);
    end
    m_addr = '0; m_size = '0; m_src = '0;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    checks++;
    if (bus.deser_splitter_rdy !== 1'b1 || bus.req_val !== 1'b0) begin
      errors++;
      $display("FAIL midreset_release got_rdy=%b val=%b exp rdy=1 val=0",
               bus.deser_splitter_rdy, bus.req_val);
    end
    words[0] = 64'h0000_0000_0000_0077;
    send_pkt(8'h10, 8'h03, 8'd3, 48'h0000_0000_6000, 3'd3, 30'h123, 0, 1'b0);
    @(negedge sys_clk);
    got = sample();
    exp = model(8'h10, 8'h03, 8'd3);
    checks++;
    if (got !== exp || got.data[DW-1:W] !== '0 || got.ndata !== 8'd1) begin
      errors++;
      $display("FAIL midreset_next got=%h exp=%h", got, exp);
    end
    release_rec();
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_overflow();
    test_malformed();
    test_back_to_back();
    test_reset_mid_data();
    repeat (2) @(posedge sys_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
